clk_sw_ctrl: RTL and testbench

CLK_SW_CTRL -- requirements
Module: clk_sw_ctrl

---
 rtl/clk_sw_pkg.sv | 22 ++
 rtl/clk_sw_guard_cnt.sv | 29 ++
 rtl/clk_sw_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_clk_sw_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_sw_pkg.sv
// Shared definitions for the clock-source switch controller.
package clk_sw_pkg;

    // Width of source-index ports (req_sel, sel_cur).
    localparam int unsigned SEL_W = 4;

    // Width of the shared guard/timeout down-counter.
    localparam int unsigned CNT_W = 8;

    // Default dead time and acknowledge-wait limit, in clk cycles.
    localparam int unsigned DEF_GUARD_CYC   = 3;
    localparam int unsigned DEF_TIMEOUT_CYC = 64;

    // Controller FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFF   = 2'd1,
        ST_GUARD = 2'd2,
        ST_ON    = 2'd3
    } state_e;

endpackage : clk_sw_pkg

// File: rtl/clk_sw_guard_cnt.sv
// Loadable down-counter with an expired flag.
// The controller uses it to time the dead interval and, when the acknowledge
// option is built in, to bound each wait on the clock mux.
module clk_sw_guard_cnt
    import clk_sw_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;

    // Load has priority; otherwise count down and stop at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule : clk_sw_guard_cnt

// File: rtl/clk_sw_ctrl.sv
// Glitch-free clock-mux switch controller.
// Sequences a source change as: drop all enables, wait a dead time, enable the
// new source. Optional feature macro CLK_SW_ACK_EN adds handshaking against the
// mux enable-status inputs (en_ack) with a per-wait timeout.
module clk_sw_ctrl
    import clk_sw_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned GUARD_CYC   = DEF_GUARD_CYC,
    parameter int unsigned RST_SRC     = 0,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [SEL_W-1:0]   req_sel,
    output logic               req_ready,
`ifdef CLK_SW_ACK_EN
    input  logic [NUM_SRC-1:0] en_ack,
`endif
    output logic [NUM_SRC-1:0] src_en,
    output logic [SEL_W-1:0]   sel_cur,
    output logic               done,
    output logic               err
);

    // A misconfigured instance never accepts a request and stays on RST_SRC.
    localparam bit PARAM_OK = (NUM_SRC >= 2) && (NUM_SRC <= 16) &&
                              (GUARD_CYC >= 1) && (GUARD_CYC <= 255) &&
                              (RST_SRC < NUM_SRC) &&
                              (TIMEOUT_CYC >= 1) && (TIMEOUT_CYC <= 255);

    localparam logic [NUM_SRC-1:0] ONE_HOT0  = {{(NUM_SRC-1){1'b0}}, 1'b1};
    localparam logic [NUM_SRC-1:0] RST_EN    = ONE_HOT0 << RST_SRC;
    localparam logic [SEL_W-1:0]   RST_SEL   = SEL_W'(RST_SRC);
    localparam logic [SEL_W:0]     NUM_SRC_X = (SEL_W+1)'(NUM_SRC);
    localparam logic [CNT_W-1:0]   GRD_LOAD  = CNT_W'(GUARD_CYC);

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] src_en_q, src_en_d;
    logic [SEL_W-1:0]   sel_cur_q, sel_cur_d;
    logic [SEL_W-1:0]   tgt_q, tgt_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               accept;
    logic               req_bad;
    logic               req_same;
    logic [NUM_SRC-1:0] tgt_onehot;
    logic               grd_load;
    logic               grd_expired;

    assign accept     = req_valid && req_ready;
    assign req_bad    = ({1'b0, req_sel} >= NUM_SRC_X);
    assign req_same   = (req_sel == sel_cur_q);
    assign tgt_onehot = ONE_HOT0 << tgt_q;

    clk_sw_guard_cnt u_guard_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (grd_load),
        .load_val_i (GRD_LOAD),
        .expired_o  (grd_expired)
    );

`ifdef CLK_SW_ACK_EN
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYC);

    logic [SEL_W-1:0] old_q, old_d;
    logic             tmo_load;
    logic             tmo_expired;
    logic             ack_old;
    logic             ack_new;

    // old_q tracks the outgoing source so a timed-out switch can fall back.
    assign ack_old = |(en_ack & (ONE_HOT0 << sel_cur_q));
    assign ack_new = |(en_ack & tgt_onehot);

    clk_sw_guard_cnt u_tmo_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmo_load),
        .load_val_i (TMO_LOAD),
        .expired_o  (tmo_expired)
    );

    // Remember the outgoing source for the fallback path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            old_q <= RST_SEL;
        end else begin
            old_q <= old_d;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !req_bad && !req_same) begin
                    state_d = ST_OFF;
                end
            end
            ST_OFF: begin
`ifdef CLK_SW_ACK_EN
                // Dead time runs here while the old source confirms it is off.
                if (grd_expired && !ack_old) begin
                    state_d = ST_ON;
                end else if (tmo_expired) begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_GUARD;
`endif
            end
            ST_GUARD: begin
                if (grd_expired) begin
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
`ifdef CLK_SW_ACK_EN
                if (ack_new || tmo_expired) begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output logic.
    always_comb begin
        req_ready = PARAM_OK && (state_q == ST_IDLE);
    end

    // Datapath next values: enables, current index, target and status pulses.
    always_comb begin
        src_en_d  = src_en_q;
        sel_cur_d = sel_cur_q;
        tgt_d     = tgt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        grd_load  = 1'b0;
`ifdef CLK_SW_ACK_EN
        old_d     = old_q;
        tmo_load  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else if (req_same) begin
                        done_d = 1'b1;
                    end else begin
                        tgt_d    = req_sel;
                        src_en_d = '0;
                        grd_load = 1'b1;
`ifdef CLK_SW_ACK_EN
                        old_d    = sel_cur_q;
                        tmo_load = 1'b1;
`endif
                    end
                end
            end
            ST_OFF: begin
`ifdef CLK_SW_ACK_EN
                if (grd_expired && !ack_old) begin
                    src_en_d  = tgt_onehot;
                    sel_cur_d = tgt_q;
                    tmo_load  = 1'b1;
                end else if (tmo_expired) begin
                    err_d    = 1'b1;
                    src_en_d = ONE_HOT0 << old_q;
                end
`endif
            end
            ST_GUARD: begin
                if (grd_expired) begin
                    src_en_d  = tgt_onehot;
                    sel_cur_d = tgt_q;
                    done_d    = 1'b1;
                end
            end
            ST_ON: begin
`ifdef CLK_SW_ACK_EN
                // New source never came up: go straight back to the old one.
                if (!ack_new && tmo_expired) begin
                    err_d     = 1'b1;
                    src_en_d  = ONE_HOT0 << old_q;
                    sel_cur_d = old_q;
                end
`endif
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_en_q  <= RST_EN;
            sel_cur_q <= RST_SEL;
            tgt_q     <= RST_SEL;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            src_en_q  <= src_en_d;
            sel_cur_q <= sel_cur_d;
            tgt_q     <= tgt_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign src_en  = src_en_q;
    assign sel_cur = sel_cur_q;
    assign err     = err_q;
`ifdef CLK_SW_ACK_EN
    // Completion is reported in the same cycle the new source is seen enabled.
    assign done    = done_q || ((state_q == ST_ON) && ack_new);
`else
    assign done    = done_q;
`endif

endmodule : clk_sw_ctrl

// File: tb/tb_clk_sw_ctrl.sv
// Testbench for clk_sw_ctrl (default parameters: NUM_SRC=4, GUARD_CYC=3).
// Also builds with CLK_SW_ACK_EN, where it models the mux acknowledge.
module tb_clk_sw_ctrl;

`ifdef CLK_SW_ACK_EN
    localparam int DONE_OFS = 5;
`else
    localparam int DONE_OFS = 4;
`endif
    localparam int ZERO_CYC = 4;  // src_en all-zero after edges E0..E0+3

    localparam int K_SWITCH = 0;
    localparam int K_SAME   = 1;
    localparam int K_ERR    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [3:0] req_sel;
    logic       req_ready;
    logic [3:0] src_en;
    logic [3:0] sel_cur;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

`ifdef CLK_SW_ACK_EN
    logic [3:0] en_ack = 4'b0000;
    logic [3:0] stuck  = 4'b0000;
    // Mux model: enable status follows src_en one cycle later.
    always @(posedge clk) en_ack <= src_en | stuck;
`endif

    clk_sw_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_ready (req_ready),
`ifdef CLK_SW_ACK_EN
        .en_ack    (en_ack),
`endif
        .src_en    (src_en),
        .sel_cur   (sel_cur),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [3:0] sel;
        int         kind;
        logic [3:0] exp_en;
        logic [3:0] exp_sel;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request from IDLE, checked cycle by cycle.
    task automatic do_req(input logic [3:0] s, input int kind,
                          input logic [3:0] exp_en, input logic [3:0] exp_sel,
                          input logic [3:0] prev_en);
        @(negedge clk);
        check("ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_sel   = s;
        @(negedge clk);  // edge E0 has passed
        req_valid = 1'b0;
        if (kind == K_SWITCH) begin
            check("off_en0", 32'(src_en), 32'd0);
            check("off_ready", 32'(req_ready), 32'd0);
            check("off_done", 32'(done), 32'd0);
            for (int k = 1; k < DONE_OFS; k++) begin
                @(negedge clk);
                if (k < ZERO_CYC) check("dead_en", 32'(src_en), 32'd0);
                check("dead_done", 32'(done), 32'd0);
                check("dead_err", 32'(err), 32'd0);
            end
            @(negedge clk);
            check("on_en", 32'(src_en), 32'(exp_en));
            check("on_sel", 32'(sel_cur), 32'(exp_sel));
            check("on_done", 32'(done), 32'd1);
            check("on_err", 32'(err), 32'd0);
            @(negedge clk);
            check("after_ready", 32'(req_ready), 32'd1);
            check("after_done", 32'(done), 32'd0);
            check("after_en", 32'(src_en), 32'(exp_en));
        end else begin
            check("imm_done", 32'(done), (kind == K_SAME) ? 32'd1 : 32'd0);
            check("imm_err", 32'(err), (kind == K_ERR) ? 32'd1 : 32'd0);
            check("imm_en", 32'(src_en), 32'(prev_en));
            check("imm_sel", 32'(sel_cur), 32'(exp_sel));
            check("imm_ready", 32'(req_ready), 32'd1);
            @(negedge clk);
            check("imm_pulse_end", 32'(done | err), 32'd0);
        end
    endtask

    initial begin
        logic [3:0] prev;

        vecs[0] = '{sel: 4'd2,  kind: K_SWITCH, exp_en: 4'b0100, exp_sel: 4'd2};
        vecs[1] = '{sel: 4'd2,  kind: K_SAME,   exp_en: 4'b0100, exp_sel: 4'd2};
        vecs[2] = '{sel: 4'd5,  kind: K_ERR,    exp_en: 4'b0100, exp_sel: 4'd2};
        vecs[3] = '{sel: 4'd1,  kind: K_SWITCH, exp_en: 4'b0010, exp_sel: 4'd1};
        vecs[4] = '{sel: 4'd15, kind: K_ERR,    exp_en: 4'b0010, exp_sel: 4'd1};
        vecs[5] = '{sel: 4'd3,  kind: K_SWITCH, exp_en: 4'b1000, exp_sel: 4'd3};
        vecs[6] = '{sel: 4'd0,  kind: K_SWITCH, exp_en: 4'b0001, exp_sel: 4'd0};
        vecs[7] = '{sel: 4'd0,  kind: K_SAME,   exp_en: 4'b0001, exp_sel: 4'd0};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_sel   = 4'd0;

        // Reset values while held and after release.
        repeat (3) @(negedge clk);
        check("rst_en", 32'(src_en), 32'h1);
        check("rst_done_err", 32'(done | err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_en", 32'(src_en), 32'h1);
        check("rel_sel", 32'(sel_cur), 32'd0);
        check("rel_ready", 32'(req_ready), 32'd1);
        check("rel_done", 32'(done), 32'd0);
        check("rel_err", 32'(err), 32'd0);

        // Table of requests applied back to back.
        prev = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            $display("vec %0d: req_sel=%0d kind=%0d", i, vecs[i].sel, vecs[i].kind);
            do_req(vecs[i].sel, vecs[i].kind, vecs[i].exp_en, vecs[i].exp_sel, prev);
            prev = vecs[i].exp_en;
        end

        // Reset two cycles into the dead time.
        $display("seq: reset during switch 0->2");
        @(negedge clk);
        req_valid = 1'b1;
        req_sel   = 4'd2;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_en", 32'(src_en), 32'd0);
        rst = 1'b1;
        #1;
        check("async_rst_en", 32'(src_en), 32'h1);
        check("async_rst_sel", 32'(sel_cur), 32'd0);
        check("async_rst_ready", 32'(req_ready), 32'd1);
        check("async_rst_done_err", 32'(done | err), 32'd0);
        @(negedge clk);
        check("rst_hold_en", 32'(src_en), 32'h1);
        rst = 1'b0;
        do_req(4'd3, K_SWITCH, 4'b1000, 4'd3, 4'b0001);

        // Request held valid through a switch; req_sel changes mid-switch.
        $display("seq: held req_valid 3->1 then 2");
        @(negedge clk);
        req_valid = 1'b1;
        req_sel   = 4'd1;
        @(negedge clk);  // E0 passed
        check("held_off_en", 32'(src_en), 32'd0);
        req_sel = 4'd2;
        for (int k = 1; k < DONE_OFS; k++) begin
            @(negedge clk);
            if (k < ZERO_CYC) check("held_dead_en", 32'(src_en), 32'd0);
            check("held_dead_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        check("held_on_en", 32'(src_en), 32'b0010);
        check("held_on_sel", 32'(sel_cur), 32'd1);
        check("held_on_done", 32'(done), 32'd1);
        @(negedge clk);
        check("held_idle_ready", 32'(req_ready), 32'd1);
        check("held_idle_en", 32'(src_en), 32'b0010);
        @(negedge clk);  // accepted on the first IDLE edge
        req_valid = 1'b0;
        check("held_acc_en", 32'(src_en), 32'd0);
        check("held_acc_ready", 32'(req_ready), 32'd0);
        repeat (DONE_OFS) @(negedge clk);
        check("held2_en", 32'(src_en), 32'b0100);
        check("held2_sel", 32'(sel_cur), 32'd2);
        check("held2_done", 32'(done), 32'd1);
        @(negedge clk);
        check("held2_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("held2_no_more", 32'(src_en), 32'b0100);
        check("held2_no_done", 32'(done), 32'd0);

`ifdef CLK_SW_ACK_EN
        // Old source acknowledge stuck high: timeout, fallback, no done.
        begin
            int  cyc;
            bit  seen_err;
            bit  seen_done;
            $display("seq: ack stuck, 2->1 times out");
            stuck = 4'b0100;
            @(negedge clk);
            req_valid = 1'b1;
            req_sel   = 4'd1;
            @(negedge clk);
            req_valid = 1'b0;
            cyc       = 0;
            seen_err  = 1'b0;
            seen_done = 1'b0;
            while (!seen_err && cyc < 100) begin
                @(negedge clk);
                cyc++;
                if (done) seen_done = 1'b1;
                if (err)  seen_err  = 1'b1;
            end
            check("tmo_err_seen", 32'(seen_err), 32'd1);
            check("tmo_cycle", 32'(cyc), 32'd65);
            check("tmo_no_done", 32'(seen_done), 32'd0);
            check("tmo_en", 32'(src_en), 32'b0100);
            check("tmo_sel", 32'(sel_cur), 32'd2);
            @(negedge clk);
            check("tmo_ready", 32'(req_ready), 32'd1);
            stuck = 4'b0000;
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // One-hot-or-zero and done/err exclusivity, checked every cycle.
    always @(negedge clk) begin
        if (!rst && ($countones(src_en) > 1 || (done && err))) begin
            n_checks++;
            n_err++;
            $display("FAIL invariant: src_en=%b done=%b err=%b", src_en, done, err);
        end
    end

endmodule : tb_clk_sw_ctrl
